sensor_coincidence_k_of_n: RTL and testbench

- Parametrised successor to the fixed three-sensor stress detector.
- Watches N_CH sensor inputs and gives each channel a retriggerable time window, counted in ticks from an internal prescaler.
- Asserts response while at least k_req enabled channels have open windows, then holds it for a minimum time.
- Adds runtime K-of-N threshold, per-channel enable, level/edge trigger mode, synchronous clear and a saturating alarm counter.

---
 rtl/sensor_coincidence_k_of_n.sv | 154 +++++++++++++++
 tb/tb_sensor_coincidence_k_of_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_coincidence_k_of_n.sv
// K-of-N sensor coincidence detector: per-channel retriggerable tick windows feeding a hold-time alarm FSM.
// Optional build macro STICKY_ALARM_EN latches response until clear or reset.
module sensor_coincidence_k_of_n #(
   parameter int N_CH     = 3,
   parameter int TICK_DIV = 100000,
   parameter int WINDOW   = 6000,
   parameter int HOLD     = 1000,
   parameter int CNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_CH-1:0]              sensor,
   input  logic [N_CH-1:0]              chan_en,
   input  logic [$clog2(N_CH+1)-1:0]    k_req,
   input  logic                         mode_edge,
   input  logic                         clear,
   output logic                         response,
   output logic [N_CH-1:0]              active,
   output logic [7:0]                   alarm_count
);

   localparam int KW = $clog2(N_CH + 1);
   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic {IDLE, ALARM} state_t;

   state_t              state, state_n;
   logic [N_CH-1:0]     s_meta, s_sync, s_prev;
   logic [N_CH-1:0]     evt;
   logic [PW-1:0]       presc;
   logic                tick;
   logic [CNT_W-1:0]    timer [N_CH];
   logic [CNT_W-1:0]    hold, hold_n;
   logic [KW-1:0]       cnt;
   logic                hit;
   logic                response_n;
   logic [7:0]          alarm_count_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_meta <= '0;
         s_sync <= '0;
         s_prev <= '0;
      end else begin
         s_meta <= sensor;
         s_sync <= s_meta;
         s_prev <= s_sync;
      end
   end

   always_comb begin
      evt = mode_edge ? (s_sync & ~s_prev) : s_sync;
   end

   // Free-running prescaler; clear deliberately leaves it alone
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         presc <= '0;
      else if (tick)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   always_comb begin
      tick = (presc == PW'(TICK_DIV - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_CH; i++)
            timer[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (clear)
               timer[i] <= '0;
            else if (evt[i])
               timer[i] <= CNT_W'(WINDOW);
            else if (tick && (timer[i] != '0))
               timer[i] <= timer[i] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++)
         active[i] = (timer[i] != '0);
   end

   // Disabled channels keep timing but are masked out of the coincidence count
   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         cnt = cnt + KW'(active[i] & chan_en[i]);
      hit = (k_req != '0) && (cnt >= k_req);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hold        <= '0;
         response    <= 1'b0;
         alarm_count <= '0;
      end else begin
         state       <= state_n;
         hold        <= hold_n;
         response    <= response_n;
         alarm_count <= alarm_count_n;
      end
   end

   always_comb begin
      state_n       = state;
      hold_n        = hold;
      response_n    = response;
      alarm_count_n = alarm_count;
      if (clear) begin
         state_n    = IDLE;
         hold_n     = '0;
         response_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  state_n    = ALARM;
                  hold_n     = CNT_W'(HOLD);
                  response_n = 1'b1;
                  if (alarm_count != 8'hFF)
                     alarm_count_n = alarm_count + 8'd1;
               end
            end
            ALARM: begin
`ifdef STICKY_ALARM_EN
               if ((hold != '0) && tick)
                  hold_n = hold - CNT_W'(1);
`else
               if (hold != '0) begin
                  if (tick)
                     hold_n = hold - CNT_W'(1);
               end else if (!hit) begin
                  state_n    = IDLE;
                  response_n = 1'b0;
               end
`endif
            end
            default: begin
               state_n    = IDLE;
               response_n = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_coincidence_k_of_n.sv
// Self-checking bench: directed scenarios plus random stimulus against a cycle-level behavioural model.
module tb_sensor_coincidence_k_of_n;

   localparam int N_CH     = 3;
   localparam int TICK_DIV = 4;
   localparam int WINDOW   = 10;
   localparam int HOLD     = 3;
   localparam int CNT_W    = 16;
   localparam int KW       = $clog2(N_CH + 1);
`ifdef STICKY_ALARM_EN
   localparam bit STICKY   = 1'b1;
`else
   localparam bit STICKY   = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N_CH-1:0]   sensor = '0;
   logic [N_CH-1:0]   chan_en = '1;
   logic [KW-1:0]     k_req = KW'(3);
   logic              mode_edge = 1'b0;
   logic              clear = 1'b0;
   logic              response;
   logic [N_CH-1:0]   active;
   logic [7:0]        alarm_count;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   int              m_timer [N_CH];
   int              m_hold, m_presc, m_cnt;
   bit              m_alarm;
   bit [N_CH-1:0]   m_meta, m_sync, m_prev;

   sensor_coincidence_k_of_n #(
      .N_CH(N_CH), .TICK_DIV(TICK_DIV), .WINDOW(WINDOW), .HOLD(HOLD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .sensor(sensor), .chan_en(chan_en), .k_req(k_req),
      .mode_edge(mode_edge), .clear(clear), .response(response), .active(active),
      .alarm_count(alarm_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N_CH; i++) m_timer[i] = 0;
      m_hold = 0; m_presc = 0; m_cnt = 0; m_alarm = 0;
      m_meta = '0; m_sync = '0; m_prev = '0;
   endfunction

   function automatic logic [N_CH-1:0] exp_active();
      logic [N_CH-1:0] a;
      for (int i = 0; i < N_CH; i++) a[i] = (m_timer[i] > 0);
      return a;
   endfunction

   // One clock of the model, from the inputs currently applied
   function automatic void model_clock();
      bit evt, tick, hit;
      int n_open;
      tick = (m_presc == TICK_DIV - 1);
      n_open = 0;
      for (int i = 0; i < N_CH; i++)
         if (m_timer[i] > 0 && chan_en[i]) n_open++;
      hit = (k_req != 0) && (n_open >= int'(k_req));
      for (int i = 0; i < N_CH; i++) begin
         evt = mode_edge ? (m_sync[i] && !m_prev[i]) : m_sync[i];
         if (clear)                      m_timer[i] = 0;
         else if (evt)                   m_timer[i] = WINDOW;
         else if (tick && m_timer[i] > 0) m_timer[i] = m_timer[i] - 1;
      end
      if (clear) begin
         m_alarm = 0; m_hold = 0;
      end else if (!m_alarm) begin
         if (hit) begin
            m_alarm = 1; m_hold = HOLD;
            if (m_cnt < 255) m_cnt++;
         end
      end else if (m_hold > 0) begin
         if (tick) m_hold--;
      end else if (!hit && !STICKY) begin
         m_alarm = 0;
      end
      m_presc = (m_presc + 1) % TICK_DIV;
      m_prev = m_sync; m_sync = m_meta; m_meta = sensor;
   endfunction

   task automatic step();
      model_clock();
      @(posedge clk);
      @(negedge clk);
      check("response", response, m_alarm);
      check("active", active, exp_active());
      check("alarm_count", alarm_count, m_cnt);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input logic [N_CH-1:0] m);
      sensor = m;
      step();
      sensor = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_response", response, 0);
      check("rst_active", active, 0);
      check("rst_alarm_count", alarm_count, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int rises, win_len, saved;
      logic prev_r, saw_resp;
      model_reset();
      @(negedge clk);
      do_reset();

      // Test 1: level mode, staggered pulses, 3-of-3
      chan_en = 3'b111; k_req = 2'd3; mode_edge = 1'b0;
      pulse(3'b001); steps(7);
      pulse(3'b010); steps(7);
      pulse(3'b100); steps(3);
      check("t1_active", active, 3'b111);
      check("t1_response", response, 1);
      check("t1_count", alarm_count, 1);

      // Test 2: windows expire before the next channel fires
      do_reset();
      saw_resp = 1'b0; win_len = 0;
      pulse(3'b001);
      for (int i = 0; i < 44; i++) begin
         step();
         if (active[0]) win_len++;
         if (response) saw_resp = 1'b1;
      end
      pulse(3'b010);
      for (int i = 0; i < 44; i++) begin step(); if (response) saw_resp = 1'b1; end
      pulse(3'b100);
      for (int i = 0; i < 10; i++) begin step(); if (response) saw_resp = 1'b1; end
      check("t2_no_response", saw_resp, 0);
      check("t2_win0_len_ok", (win_len >= 36 && win_len <= 44), 1);

      // Test 3: 2-of-N with channel 1 masked
      do_reset();
      k_req = 2'd2; chan_en = 3'b101;
      pulse(3'b001); steps(2);
      pulse(3'b010); steps(6);
      check("t3_masked", response, 0);
      pulse(3'b100); steps(4);
      check("t3_hit", response, 1);
      k_req = 2'd3; chan_en = 3'b111;

      // Test 4: edge mode with sensors held high
      do_reset();
      mode_edge = 1'b1; sensor = 3'b111;
      rises = 0; prev_r = 1'b0;
      for (int i = 0; i < 90; i++) begin
         step();
         if (response && !prev_r) rises++;
         prev_r = response;
      end
      check("t4_rises", rises, 1);
      check("t4_final_response", response, STICKY);
      check("t4_count", alarm_count, 1);
      sensor = '0; mode_edge = 1'b0;
      clear = 1'b1; step(); clear = 1'b0;

      // Test 5: clear during ALARM, then k_req=0
      do_reset();
      pulse(3'b111); steps(5);
      check("t5_in_alarm", response, 1);
      saved = alarm_count;
      clear = 1'b1; step(); clear = 1'b0;
      check("t5_clr_response", response, 0);
      check("t5_clr_active", active, 0);
      check("t5_count_kept", alarm_count, saved);
      k_req = '0;
      pulse(3'b111); steps(5);
      check("t5_k0_active", active, 3'b111);
      check("t5_k0_response", response, 0);
      k_req = 2'd3;

      // Test 6: reset mid-window, then long wait past expiry
      do_reset();
      pulse(3'b111); steps(6);
      do_reset();
      pulse(3'b111); steps(80);
      check("t6_after_expiry", response, STICKY);
      check("t6_windows_closed", active, 0);
      clear = 1'b1; step(); clear = 1'b0;
      check("t6_after_clear", response, 0);

      // Random phase
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (i % 50 == 0) begin
            chan_en = N_CH'($urandom);
            k_req = KW'($urandom_range(0, 3));
         end
         if (i % 100 == 0) mode_edge = 1'($urandom);
         for (int b = 0; b < N_CH; b++)
            sensor[b] = ($urandom_range(0, 11) == 0);
         clear = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 399) == 0) begin
            clear = 1'b0;
            do_reset();
         end
         step();
      end
      clear = 1'b0; sensor = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
